// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: load-use bubbles, branch flushes, data-memory
// freeze with timeout trap, and saturating performance counters.
module hazard_controller #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             use_rs1_id,
  input  logic             use_rs2_id,
  input  logic [4:0]       rd_ex,
  input  logic             MemRdex,
  input  logic             branch_taken_ex,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             clr_cnt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mem_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  state_t      state;
  logic [15:0] wait_cnt;
  logic        frozen;
  logic        load_use;
  logic        timeout_hit;
  logic        lu_evt;
  logic        flush_evt;

  always_comb begin
    frozen      = dmem_req & ~dmem_ready & (state != ERROR);
    load_use    = MemRdex & (rd_ex != '0) &
                  ((use_rs1_id & (rs1_id == rd_ex)) | (use_rs2_id & (rs2_id == rd_ex)));
    timeout_hit = frozen & (wait_cnt == 16'(MEM_TIMEOUT));
    // Branch outranks load-use; freeze outranks both.
    flush_evt   = (state != ERROR) & ~frozen & branch_taken_ex;
    lu_evt      = (state != ERROR) & ~frozen & ~branch_taken_ex & load_use;
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    if (rst) begin
      {pc_en, ifid_en, idex_en, exmem_en} = '0;
      {ifid_flush, idex_flush, memwb_flush} = '1;
    end else if (state == ERROR) begin
      {pc_en, ifid_en, idex_en, exmem_en} = '0;
    end else if (frozen) begin
      {pc_en, ifid_en, idex_en, exmem_en} = '0;
      memwb_flush = 1'b1;
    end else if (branch_taken_ex) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      lu_cnt      <= '0;
      mem_cnt     <= '0;
      flush_cnt   <= '0;
    end else begin
      if (timeout_hit) begin
        state       <= ERROR;
        mem_timeout <= 1'b1;
      end else begin
        case (state)
          RUN: begin
            if (frozen) begin
              state    <= MEM_WAIT;
              wait_cnt <= 16'd1;
            end
          end
          MEM_WAIT: begin
            if (frozen) begin
              wait_cnt <= wait_cnt + 16'd1;
            end else begin
              state    <= RUN;
              wait_cnt <= '0;
            end
          end
          ERROR:   state <= ERROR;
          default: state <= RUN;
        endcase
      end

      if (clr_cnt) begin
        lu_cnt    <= '0;
        mem_cnt   <= '0;
        flush_cnt <= '0;
      end else begin
        if (lu_evt && lu_cnt != '1)       lu_cnt    <= lu_cnt + 1'b1;
        if (frozen && mem_cnt != '1)      mem_cnt   <= mem_cnt + 1'b1;
        if (flush_evt && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller (MEM_TIMEOUT = 4, CNT_W = 4) with a
// scoreboard of expected enables/flushes and counter values per cycle.
module tb_hazard_controller;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       rs1_id, rs2_id, rd_ex;
  logic             use_rs1_id, use_rs2_id, MemRdex, branch_taken_ex;
  logic             dmem_req, dmem_ready, clr_cnt;
  logic             pc_en, ifid_en, idex_en, exmem_en;
  logic             ifid_flush, idex_flush, memwb_flush, mem_timeout;
  logic [CNT_W-1:0] lu_cnt, mem_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_controller #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .rd_ex(rd_ex), .MemRdex(MemRdex), .branch_taken_ex(branch_taken_ex),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .clr_cnt(clr_cnt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
    .mem_timeout(mem_timeout), .lu_cnt(lu_cnt), .mem_cnt(mem_cnt), .flush_cnt(flush_cnt)
  );

  // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush}
  localparam logic [6:0] C_RUN = 7'b1111_000;
  localparam logic [6:0] C_LU  = 7'b0011_010;
  localparam logic [6:0] C_BR  = 7'b1111_110;
  localparam logic [6:0] C_FRZ = 7'b0000_001;
  localparam logic [6:0] C_ERR = 7'b0000_000;
  localparam logic [6:0] C_RST = 7'b0000_111;

  typedef struct {
    string       tag;
    logic [6:0]  comb;
    int unsigned lu, mem, fl;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] obs_comb;
  assign obs_comb = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are already applied; check outputs of this cycle, then registers after the edge.
  task automatic step(input string tag, input logic [6:0] comb, input int unsigned lu,
                      input int unsigned mem, input int unsigned fl, input logic to);
    exp_t e, got;
    e.tag = tag; e.comb = comb; e.lu = lu; e.mem = mem; e.fl = fl; e.to = to;
    sb.push_back(e);
    #1;
    got = sb.pop_front();
    check({got.tag, "_ctl"}, 32'(obs_comb), 32'(got.comb));
    @(posedge clk);
    #1;
    check({got.tag, "_lu"},  32'(lu_cnt),    got.lu);
    check({got.tag, "_mem"}, 32'(mem_cnt),   got.mem);
    check({got.tag, "_fl"},  32'(flush_cnt), got.fl);
    check({got.tag, "_to"},  32'(mem_timeout), 32'(got.to));
  endtask

  task automatic idle_inputs();
    rs1_id = '0; rs2_id = '0; rd_ex = '0;
    use_rs1_id = 0; use_rs2_id = 0; MemRdex = 0; branch_taken_ex = 0;
    dmem_req = 0; dmem_ready = 0; clr_cnt = 0;
  endtask

  task automatic lu_match();
    MemRdex = 1; rd_ex = 5'd5; rs1_id = 5'd5; use_rs1_id = 1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    rst = 1;
    step("reset0", C_RST, 0, 0, 0, 0);
    step("reset1", C_RST, 0, 0, 0, 0);
    rst = 0;
    step("idle", C_RUN, 0, 0, 0, 0);

    lu_match();
    step("lu_rs1", C_LU, 1, 0, 0, 0);
    idle_inputs();
    step("after_lu", C_RUN, 1, 0, 0, 0);
    MemRdex = 1; rd_ex = 5'd0; rs1_id = 5'd0; use_rs1_id = 1;
    step("lu_x0", C_RUN, 1, 0, 0, 0);
    rd_ex = 5'd5; rs1_id = 5'd5; use_rs1_id = 0;
    step("lu_nouse", C_RUN, 1, 0, 0, 0);
    rd_ex = 5'd7; rs1_id = 5'd3; use_rs1_id = 1; rs2_id = 5'd7; use_rs2_id = 1;
    step("lu_rs2", C_LU, 2, 0, 0, 0);
    idle_inputs();

    lu_match(); branch_taken_ex = 1;
    step("br_lu", C_BR, 2, 0, 1, 0);
    idle_inputs();
    step("after_br", C_RUN, 2, 0, 1, 0);

    // Branch and load-use held in EX across a 3-cycle freeze.
    lu_match(); branch_taken_ex = 1; dmem_req = 1; dmem_ready = 0;
    for (int i = 1; i <= 3; i++) step("freeze", C_FRZ, 2, i, 1, 0);
    dmem_ready = 1;
    step("unfreeze_br", C_BR, 2, 3, 2, 0);
    idle_inputs();
    step("after_mem", C_RUN, 2, 3, 2, 0);
    dmem_req = 1; dmem_ready = 1;
    step("ready_first", C_RUN, 2, 3, 2, 0);

    // Timeout: freeze cycle 5 traps with MEM_TIMEOUT = 4.
    dmem_ready = 0;
    for (int i = 1; i <= 4; i++) step("to_frz", C_FRZ, 2, 3 + i, 2, 0);
    step("to_frz5", C_FRZ, 2, 8, 2, 1);
    lu_match(); branch_taken_ex = 1;
    step("error", C_ERR, 2, 8, 2, 1);
    idle_inputs();
    step("error_hold", C_ERR, 2, 8, 2, 1);
    rst = 1;
    step("rst_err", C_RST, 0, 0, 0, 0);
    rst = 0;
    step("post_err", C_RUN, 0, 0, 0, 0);

    // Reset mid-wait leaves no residual freeze.
    dmem_req = 1; dmem_ready = 0;
    step("mw_frz1", C_FRZ, 0, 1, 0, 0);
    step("mw_frz2", C_FRZ, 0, 2, 0, 0);
    rst = 1;
    step("rst_mw", C_RST, 0, 0, 0, 0);
    rst = 0; dmem_ready = 1;
    step("post_mw", C_RUN, 0, 0, 0, 0);
    idle_inputs();

    // Saturation of a 4-bit counter, then clear winning over an increment.
    lu_match();
    for (int i = 1; i <= 20; i++) step("lu_sat", C_LU, (i > 15) ? 15 : i, 0, 0, 0);
    clr_cnt = 1;
    step("clr", C_LU, 0, 0, 0, 0);
    idle_inputs();
    step("after_clr", C_RUN, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencing controller for the 5-stage RISC-V core. It drives the enable and flush inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and it inserts the load-use bubble that forwarding cannot cover. It also redirects on taken branches, freezes the pipe while the data memory is not ready, and traps memory timeouts. Saturating stall and flush counters support performance debug.

## Interface
- MEM_TIMEOUT, 255: maximum consecutive memory-freeze cycles allowed per access; range 1..2^16-1.
- CNT_W, 16: width of each performance counter.
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rs1_id, rs2_id  in  5 each  source registers of the instruction in ID.
- use_rs1_id, use_rs2_id  in  1 each  the ID instruction actually reads rs1 / rs2.
- rd_ex  in  5  destination register of the instruction in EX.
- MemRdex  in  1  the EX instruction is a load.
- branch_taken_ex  in  1  branch or jump resolved taken in EX.
- dmem_req  in  1  the MEM-stage instruction accesses data memory this cycle.
- dmem_ready  in  1  data memory completes the access this cycle.
- clr_cnt  in  1  synchronous clear of all performance counters.
- pc_en, ifid_en, idex_en, exmem_en  out  1 each  register load enables.
- ifid_flush, idex_flush, memwb_flush  out  1 each  load a bubble (NOP, all write enables 0).
- mem_timeout  out  1  sticky error flag.
- lu_cnt, mem_cnt, flush_cnt  out  CNT_W each  saturating event counters.

## Operation
- FSM states:
  - RUN: normal operation.
  - MEM_WAIT: a data-memory access is outstanding.
  - ERROR: timeout trap.
- Internal wait_cnt, 16 bits: counts consecutive freeze cycles of the current access.
- freeze = dmem_req & !dmem_ready, in RUN or MEM_WAIT.
  - Outputs: pc_en = ifid_en = idex_en = exmem_en = 0, memwb_flush = 1, all other flushes 0.
  - Freeze has top priority; branch and load-use are ignored while freeze is high.
- branch (not frozen, branch_taken_ex = 1):
  - Outputs: all enables 1, ifid_flush = idex_flush = 1.
  - Overrides load-use in the same cycle; no load-use bubble is counted.
- load-use (not frozen, no branch): MemRdex & rd_ex != 0 & ((use_rs1_id & rs1_id == rd_ex) | (use_rs2_id & rs2_id == rd_ex)).
  - Outputs: pc_en = ifid_en = 0, idex_flush = 1, exmem_en = idex_en = 1.
- Otherwise: all enables 1, all flushes 0.
- Transitions:
  - RUN → MEM_WAIT on a freeze cycle; wait_cnt ← 1.
  - MEM_WAIT with freeze: wait_cnt ← wait_cnt + 1.
  - MEM_WAIT with !freeze (ready, or request dropped): → RUN, wait_cnt ← 0.
  - A freeze cycle with wait_cnt == MEM_TIMEOUT at its start (i.e. freeze cycle MEM_TIMEOUT+1) → ERROR.
  - ERROR: all enables 0, all flushes 0, mem_timeout = 1; held until rst.
- Counters (each saturates at 2^CNT_W-1, no wrap):
  - lu_cnt +1 per load-use bubble cycle.
  - mem_cnt +1 per freeze cycle.
  - flush_cnt +1 per branch flush cycle.
  - clr_cnt zeroes all three; clr_cnt wins over an increment in the same cycle.
  - Counters do not increment in ERROR.

## Timing
- Enable and flush outputs are combinational from state and inputs: zero latency, valid in the same cycle as the hazard.
- State, wait_cnt, mem_timeout and the counters update on the rising clk edge.
- While rst = 1:
  - Enables 0; ifid_flush = idex_flush = memwb_flush = 1.
  - On the edge: state ← RUN, wait_cnt ← 0, mem_timeout ← 0, counters ← 0.
- First cycle after rst falls: normal RUN decoding.
- rst during MEM_WAIT or ERROR: back to RUN with no residual freeze.
- dmem_ready = 1 on the first request cycle: no freeze, state stays RUN.
- A branch held in EX during a freeze is acted on in the first non-frozen cycle, since the EX inputs persist.

## Test plan
- Load x5 in EX, ID `add` with rs1 = x5 (use_rs1_id = 1) → one cycle of pc_en = 0, ifid_en = 0, idex_flush = 1; lu_cnt = 1; next cycle all enables 1.
- Same as above with rd_ex = x0, or use_rs1_id = 0 → no stall, lu_cnt stays 0.
- branch_taken_ex = 1 together with a load-use match → ifid_flush = idex_flush = 1, pc_en = 1; flush_cnt = 1, lu_cnt = 0.
- dmem_req = 1, ready low for 3 cycles then high (MEM_TIMEOUT = 4) → 3 freeze cycles with memwb_flush = 1; mem_cnt = 3; state back in RUN, mem_timeout = 0.
- MEM_TIMEOUT = 4, ready held low → ERROR after the 5th freeze cycle; mem_timeout = 1, all enables 0; rst clears it.
- CNT_W = 4, 20 load-use events → lu_cnt = 15; clr_cnt pulse → 0.
